md_button_scanner: RTL

- Upstream input stage for the Mega Drive six-button encoder.
- Polls a 16-bit external parallel-in/serial-out shift-register chain (74HC165-style) wired to the physical buttons.
- Debounces each button and drives the twelve registered, active-low button lines (up, dw, lf, rg, a, b, c, st, x, y, z, md) that the encoder consumes directly.
- Runs on the same board clock as the encoder.

---
 rtl/md_button_scanner.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/md_button_scanner.sv
// md_button_scanner: polls a 16-bit 74HC165-style chain, debounces the twelve
// Mega Drive buttons and presents them as registered active-low lines.
// Optional build macro: MD_SCANNER_SOCD_CLEAN_EN (opposite-direction cleaning).

// One debounce lane: a button output follows raw only after DEB consecutive
// disagreeing frames. deb_nxt is the value the lane will hold after this cycle.
module md_db_lane #(
    parameter int DEB = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic upd,
    input  logic raw,
    output logic deb_nxt
);
    logic [3:0] cnt_q, cnt_d;
    logic       deb_q, deb_d;

    // Counter clears on agreement, else climbs; at DEB the output flips.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (upd) begin
            if (raw == deb_q) begin
                cnt_d = '0;
            end else if (cnt_q == 4'(DEB - 1)) begin
                deb_d = raw;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Lane state; released (1) with a cleared counter out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            deb_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign deb_nxt = deb_d;
endmodule

module md_button_scanner #(
    parameter int CLK_FREQ       = 20000000,
    parameter int SCAN_HZ        = 1000,
    parameter int SHIFT_HZ       = 500000,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sr_data,
    output logic sr_load_n,
    output logic sr_clk,
    output logic up,
    output logic dw,
    output logic lf,
    output logic rg,
    output logic a,
    output logic b,
    output logic c,
    output logic st,
    output logic x,
    output logic y,
    output logic z,
    output logic md,
    output logic frame_valid
);
    localparam int NUM_BTN = 12;
    localparam int SP      = CLK_FREQ / SCAN_HZ;
    localparam int HP_RAW  = CLK_FREQ / (2 * SHIFT_HZ);
    localparam int HP      = (HP_RAW < 1) ? 1 : HP_RAW;
    localparam int SP_W    = (SP > 1) ? $clog2(SP) : 1;
    localparam int PH_W    = (HP > 1) ? $clog2(HP) : 1;

    // A frame must fit between ticks with margin, and the counter is 4 bits.
    generate
        if (SP <= 34 * HP) begin : g_bad_period
            $error("md_button_scanner: scan period must exceed 34 shift half-periods");
        end
        if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_deb
            $error("md_button_scanner: DEBOUNCE_SCANS must be 1..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           rst_sync_q;
    logic                 run;
    logic [SP_W-1:0]      timer_q, timer_d;
    logic                 tick;
    logic [PH_W-1:0]      ph_q, ph_d;
    logic                 ph_last;
    logic [3:0]           bit_q, bit_d;
    logic [NUM_BTN-1:0]   raw_q, raw_d;
    logic [NUM_BTN-1:0]   deb_nxt;
    logic [NUM_BTN-1:0]   clean;
    logic [NUM_BTN-1:0]   out_q, out_d;
    logic                 upd;
    logic                 sr_load_n_q, sr_load_n_d;
    logic                 sr_clk_q, sr_clk_d;
    logic                 frame_valid_q, frame_valid_d;

    // Reset release is brought onto the clock before the scan timer may run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign run = rst_sync_q[1];

    // Free-running frame timer; tick on its last count.
    always_comb begin
        timer_d = timer_q;
        if (!run)                            timer_d = '0;
        else if (timer_q == SP_W'(SP - 1))   timer_d = '0;
        else                                 timer_d = timer_q + 1'b1;
    end
    assign tick = run && (timer_q == SP_W'(SP - 1));

    assign ph_last = (ph_q == PH_W'(HP - 1));

    // Scan sequencer: load pulse, then 16 low/high shift phases, then DONE.
    // Ticks outside IDLE are simply ignored (dropped).
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        raw_d   = raw_q;
        case (state_q)
            ST_IDLE: begin
                ph_d = '0;
                if (tick) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (ph_last) begin
                    ph_d    = '0;
                    bit_d   = 4'd0;
                    state_d = ST_SHIFT_LO;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_SHIFT_LO: begin
                if (ph_last) begin
                    ph_d = '0;
                    // Bits 12..15 of the chain are clocked through but unused.
                    for (int i = 0; i < NUM_BTN; i++) begin
                        if (bit_q == 4'(i)) raw_d[i] = sr_data;
                    end
                    state_d = (bit_q == 4'd15) ? ST_DONE : ST_SHIFT_HI;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                if (ph_last) begin
                    ph_d    = '0;
                    bit_d   = bit_q + 4'd1;
                    state_d = ST_SHIFT_LO;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign upd = (state_q == ST_DONE);

    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
            md_db_lane #(.DEB(DEBOUNCE_SCANS)) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .upd     (upd),
                .raw     (raw_q[i]),
                .deb_nxt (deb_nxt[i])
            );
        end
    endgenerate

    // Debounced values go to the pins, optionally with opposite directions resolved.
    always_comb begin
        clean = deb_nxt;
`ifdef MD_SCANNER_SOCD_CLEAN_EN
        // Left+right pressed -> neutral; up+down pressed -> up wins.
        if (!clean[2] && !clean[3]) clean[3:2] = 2'b11;
        if (!clean[0] && !clean[1]) clean[1]   = 1'b1;
`endif
    end

    // Next values of the registered pins; chain strobes mirror the next state.
    always_comb begin
        out_d         = upd ? clean : out_q;
        sr_load_n_d   = (state_d != ST_LOAD);
        sr_clk_d      = (state_d == ST_SHIFT_HI);
        frame_valid_d = upd;
    end

    // All sequencer and pin state; reset is asynchronous so pins release at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            ph_q          <= '0;
            bit_q         <= '0;
            raw_q         <= '1;
            out_q         <= '1;
            sr_load_n_q   <= 1'b1;
            sr_clk_q      <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ph_q          <= ph_d;
            bit_q         <= bit_d;
            raw_q         <= raw_d;
            out_q         <= out_d;
            sr_load_n_q   <= sr_load_n_d;
            sr_clk_q      <= sr_clk_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign sr_load_n   = sr_load_n_q;
    assign sr_clk      = sr_clk_q;
    assign frame_valid = frame_valid_q;
    assign {md, z, y, x, st, c, b, a, rg, lf, dw, up} = out_q;
endmodule
